// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit L2 line request to four 64-bit physical-memory beats.
// Define CLA_EARLY_RESP_EN to return line_resp in the cycle of the last beat instead of a DONE cycle.
module cacheline_adaptor #(
  parameter int s_offset = 5,
  parameter int s_beats  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         line_read,
  input  logic         line_write,
  input  logic [31:0]  line_address,
  input  logic [255:0] line_wdata,
  output logic [255:0] line_rdata,
  output logic         line_resp,
  output logic [31:0]  burst_address,
  output logic         burst_read,
  output logic         burst_write,
  output logic [63:0]  burst_wdata,
  input  logic [63:0]  burst_rdata,
  input  logic         burst_resp
);

  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << s_offset) - 32'd1);
  localparam logic [1:0]  LAST_BEAT  = 2'(s_beats - 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  state_t         state, state_next;
  logic [1:0]     cnt;
  logic [255:0]   line_q;
  logic [255:0]   wdata_q;
  logic [31:0]    addr_q;
  logic           in_burst;
  logic           last_beat;

  assign in_burst  = (state == RD_BURST) || (state == WR_BURST);
  assign last_beat = in_burst && burst_resp && (cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      line_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (line_write) begin
            addr_q  <= line_address;
            wdata_q <= line_wdata;
            cnt     <= 2'd0;
          end else if (line_read) begin
            addr_q <= line_address;
            cnt    <= 2'd0;
          end
        end
        RD_BURST: begin
          if (burst_resp) begin
            line_q[{cnt, 6'b0} +: 64] <= burst_rdata;
            cnt                       <= cnt + 2'd1;
          end
        end
        WR_BURST: begin
          if (burst_resp) cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (line_write)     state_next = WR_BURST;
        else if (line_read) state_next = RD_BURST;
      end
      RD_BURST, WR_BURST: begin
`ifdef CLA_EARLY_RESP_EN
        if (last_beat) state_next = IDLE;
`else
        if (last_beat) state_next = DONE;
`endif
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    burst_read    = (state == RD_BURST);
    burst_write   = (state == WR_BURST);
    burst_address = in_burst ? (addr_q & ALIGN_MASK) : 32'd0;
    burst_wdata   = (state == WR_BURST) ? wdata_q[{cnt, 6'b0} +: 64] : 64'd0;
    line_rdata    = line_q;
`ifdef CLA_EARLY_RESP_EN
    // Last beat has not reached line_q yet, so forward it straight to the requester.
    line_resp = rst && last_beat;
    if ((state == RD_BURST) && last_beat) line_rdata = {burst_rdata, line_q[191:0]};
`else
    line_resp = (state == DONE);
`endif
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: stimulus queues expected beats/responses, a negedge monitor checks them.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read, line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_address;
  logic         burst_read, burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .line_read(line_read), .line_write(line_write),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_address(burst_address), .burst_read(burst_read), .burst_write(burst_write),
    .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;

`ifdef CLA_EARLY_RESP_EN
  localparam int RESP_LAT = 0;
`else
  localparam int RESP_LAT = 1;
`endif

  typedef struct { logic wr; logic [31:0] addr; logic [63:0] wdata; } beat_t;
  typedef struct { logic rd; logic [255:0] line; } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int resp_cyc = 0;
  int last_beat_cyc = 0;
  int wr_hi = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops and compares on every consumed beat and every line response.
  always @(negedge clk) begin
    if (rst && burst_write) wr_hi++;
    if (rst && burst_resp && (burst_read || burst_write)) begin
      if (beat_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        beat_t b;
        b = beat_q.pop_front();
        chk("beat_kind", burst_write, b.wr);
        chk("burst_address", burst_address, b.addr);
        if (b.wr) chk("burst_wdata", burst_wdata, b.wdata);
      end
    end
    if (line_resp) begin
      resp_cnt++;
      resp_cyc = cyc;
      if (resp_q.size() == 0) begin
        chk("unexpected_line_resp", 1, 0);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        if (r.rd) chk("line_rdata", line_rdata, r.line);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input logic wr, input logic [31:0] addr, input logic [255:0] wd);
    for (int k = 0; k < 4; k++) begin
      beat_t b;
      b.wr = wr; b.addr = addr; b.wdata = wd[64*k +: 64];
      beat_q.push_back(b);
    end
  endtask

  task automatic push_resp(input logic rd, input logic [255:0] line);
    resp_t r;
    r.rd = rd; r.line = line;
    resp_q.push_back(r);
  endtask

  task automatic drive_beats(input logic [255:0] rline, input int gap, input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          burst_resp = 1'b0;
          tick();
        end
      end
      burst_resp  = 1'b1;
      burst_rdata = rline[64*k +: 64];
      if (k == 3) last_beat_cyc = cyc;
      tick();
    end
    burst_resp  = 1'b0;
    burst_rdata = '0;
  endtask

  task automatic wait_resp(input int target, input string name);
    int n;
    n = 0;
    while (resp_cnt < target && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (resp_cnt < target) chk({name, "_resp_timeout"}, 0, 1);
    tick();
  endtask

  logic [255:0] rd_line1, rd_line2, rd_line3, wr_line;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; line_read = 0; line_write = 0; line_address = '0; line_wdata = '0;
    burst_rdata = '0; burst_resp = 0;
    rd_line1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    rd_line2 = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    rd_line3 = {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321};
    wr_line  = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_line_rdata", line_rdata, 256'd0);
    chk("rst_line_resp", line_resp, 0);
    chk("rst_burst_address", burst_address, 0);
    chk("rst_burst_read", burst_read, 0);
    chk("rst_burst_write", burst_write, 0);
    chk("rst_burst_wdata", burst_wdata, 0);
    tick();

    // Back-to-back read, address unaligned
    push_beats(0, 32'h0000_1220, '0);
    push_resp(1, rd_line1);
    line_read = 1; line_address = 32'h0000_1234;
    tick();
    line_read = 0; line_address = 32'hFFFF_FFFF;
    drive_beats(rd_line1, 0, 4);
    wait_resp(1, "read1");
    chk("read1_resp_latency", resp_cyc - last_beat_cyc, RESP_LAT);
    chk("read1_hold_rdata", line_rdata, rd_line1);

    // Write with 2-cycle gaps; inputs scrambled after latch
    push_beats(1, 32'h0000_8000, wr_line);
    push_resp(0, '0);
    wr_hi = 0;
    line_write = 1; line_address = 32'h0000_8000; line_wdata = wr_line;
    tick();
    line_write = 0; line_address = 32'h1357_9BDF; line_wdata = {8{32'hCAFE_F00D}};
    drive_beats('0, 2, 4);
    wait_resp(2, "write1");
    chk("write1_burst_write_cycles", wr_hi, 10);
    chk("write_keeps_rdata", line_rdata, rd_line1);

    // Simultaneous read+write: write wins
    push_beats(1, 32'h0000_4040, {8{32'h5A5A_A5A5}});
    push_resp(0, '0);
    line_read = 1; line_write = 1; line_address = 32'h0000_4047;
    line_wdata = {8{32'h5A5A_A5A5}};
    tick();
    line_read = 0; line_write = 0;
    chk("both_burst_read", burst_read, 0);
    chk("both_burst_write", burst_write, 1);
    drive_beats('0, 1, 4);
    wait_resp(3, "both");

    // Reset mid-read after two beats
    push_beats(0, 32'h0000_2000, '0);
    line_read = 1; line_address = 32'h0000_2010;
    tick();
    line_read = 0;
    drive_beats(rd_line3, 0, 2);
    while (beat_q.size() > 0) void'(beat_q.pop_front());
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_burst_read", burst_read, 0);
    chk("abort_line_rdata_cleared", line_rdata, 256'd0);
    repeat (3) tick();
    chk("abort_no_resp", resp_cnt, 3);

    // Read after abort completes from beat 0
    push_beats(0, 32'h0000_2000, '0);
    push_resp(1, rd_line2);
    line_read = 1; line_address = 32'h0000_2010;
    tick();
    line_read = 0;
    drive_beats(rd_line2, 3, 4);
    wait_resp(4, "post_abort");

    // Spurious burst_resp in IDLE, then a read
    burst_resp = 1; burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    repeat (2) tick();
    burst_resp = 0;
    chk("spurious_no_resp", resp_cnt, 4);
    chk("spurious_idle_read", burst_read, 0);
    push_beats(0, 32'hFFFF_FFE0, '0);
    push_resp(1, rd_line3);
    line_read = 1; line_address = 32'hFFFF_FFFF;
    tick();
    line_read = 0;
    drive_beats(rd_line3, 0, 4);
    wait_resp(5, "spurious");

    // Request held past line_resp restarts on the same line
    push_beats(0, 32'h0000_1220, '0);
    push_resp(1, rd_line1);
    push_beats(0, 32'h0000_1220, '0);
    push_resp(1, rd_line2);
    line_read = 1; line_address = 32'h0000_1234;
    tick();
    drive_beats(rd_line1, 0, 4);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!(burst_read && resp_cnt == 6) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("held_restart_seen", burst_read && resp_cnt == 6, 1);
    end
    line_read = 0;
    tick();
    drive_beats(rd_line2, 0, 4);
    wait_resp(7, "held_second");

    repeat (3) tick();
    chk("beat_q_empty", beat_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);
    chk("resp_count", resp_cnt, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
